// File: rtl/polar_pkg.sv
// =============================================================================
// Module : polar_pkg
// Brief  : Shared types and helpers for the polar encoder (N codes, FSM states,
//          log2(N) lookup, bit-reversal index helper).
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

package polar_pkg;

    localparam int c_DW   = 64;
    localparam int c_NMAX = 512;

    typedef enum logic [1:0] {
        NC_128  = 2'd0,
        NC_256  = 2'd1,
        NC_512  = 2'd2,
        NC_512X = 2'd3
    } ncode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_CNT = 3'd1,
        ST_RD_HDR = 3'd2,
        ST_LOAD   = 3'd3,
        ST_ENC    = 3'd4,
        ST_STORE  = 3'd5,
        ST_DONE   = 3'd6
    } state_e;

    // The reserved code 3 decodes as 512.
    function automatic logic [3:0] ncode_log2(input ncode_e c);
        case (c)
            NC_128:  return 4'd7;
            NC_256:  return 4'd8;
            default: return 4'd9;
        endcase
    endfunction

    function automatic int bitrev(input int i, input int n);
        int r;
        r = 0;
        for (int b = 0; b < n; b++) begin
            if (((i >> b) & 1) != 0) r = r | (1 << (n - 1 - b));
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/polar_enc_stage.sv
// =============================================================================
// Module : polar_enc_stage
// Brief  : One butterfly stage of the polar transform: v[i] ^= v[i+2^s] for
//          every i with bit s clear.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

module polar_enc_stage
    import polar_pkg::*;
#(
    parameter int NMAX = c_NMAX
) (
    input  logic [NMAX-1:0] i_v,
    input  logic [3:0]      i_stage,
    output logic [NMAX-1:0] o_v
);

    localparam int LOGN = $clog2(NMAX);

    logic [LOGN-1:0][NMAX-1:0] w_stg;

    for (genvar s = 0; s < LOGN; s++) begin : g_stage
        for (genvar i = 0; i < NMAX; i++) begin : g_bit
            if (((i >> s) & 1) == 0) begin : g_xor
                assign w_stg[s][i] = i_v[i] ^ i_v[i + (1 << s)];
            end else begin : g_pass
                assign w_stg[s][i] = i_v[i];
            end
        end
    end

    always_comb begin
        o_v = i_v;
        for (int s = 0; s < LOGN; s++) begin
            if (i_stage == 4'(s)) o_v = w_stg[s];
        end
    end

endmodule

`default_nettype wire

// File: rtl/polar_encoder.sv
// =============================================================================
// Module : polar_encoder
// Brief  : Multi-packet polar encoder: reads packets from u-memory, applies
//          x = u*F^(xn) one stage per cycle, writes codewords to x-memory.
//          Optional macro POLAR_ENC_BITREV_EN emits codewords bit-reversed.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

module polar_encoder
    import polar_pkg::*;
#(
    parameter int DW   = c_DW,
    parameter int NMAX = c_NMAX,
    parameter int AW   = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          module_en,
    output logic          proc_done,
    output logic [AW-1:0] raddr,
    input  logic [DW-1:0] rdata,
    output logic          wen,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata
);

    localparam int CW    = $clog2(NMAX + 1);
    localparam int WIDXW = $clog2(NMAX / DW);

    state_e            r_state, w_next;
    logic [CW-1:0]     r_cnt;
    logic [5:0]        r_pkts;
    ncode_e            r_ncode;
    logic [NMAX-1:0]   r_v, w_stage_v, w_xout;
    logic [AW-1:0]     r_raddr, r_waddr;
    logic [3:0]        w_logn;
    logic [CW-1:0]     w_words, w_last_stage;
    logic [WIDXW-1:0]  w_lidx, w_sidx;

    assign w_logn       = ncode_log2(r_ncode);
    assign w_words      = CW'((32'd1 << w_logn) / DW);
    assign w_last_stage = CW'(w_logn) - CW'(1);
    assign w_lidx       = WIDXW'(r_cnt - CW'(1));
    assign w_sidx       = r_cnt[WIDXW-1:0];

    polar_enc_stage #(.NMAX(NMAX)) u_stage (
        .i_v     (r_v),
        .i_stage (r_cnt[3:0]),
        .o_v     (w_stage_v)
    );

`ifdef POLAR_ENC_BITREV_EN
    logic [2:0][NMAX-1:0] w_rev;

    for (genvar g = 0; g < 3; g++) begin : g_rev
        for (genvar i = 0; i < NMAX; i++) begin : g_bit
            if (((128 << g) <= NMAX) && (i < (128 << g))) begin : g_map
                assign w_rev[g][i] = r_v[bitrev(i, 7 + g)];
            end else begin : g_zero
                assign w_rev[g][i] = 1'b0;
            end
        end
    end

    always_comb begin
        case (r_ncode)
            NC_128:  w_xout = w_rev[0];
            NC_256:  w_xout = w_rev[1];
            default: w_xout = w_rev[2];
        endcase
    end
`else
    assign w_xout = r_v;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (module_en) w_next = ST_RD_CNT;
            ST_RD_CNT: if (r_cnt == CW'(1))
                           w_next = (rdata[5:0] == 6'd0) ? ST_DONE : ST_RD_HDR;
            ST_RD_HDR: if (r_cnt == CW'(1)) w_next = ST_LOAD;
            ST_LOAD:   if (r_cnt == w_words) w_next = ST_ENC;
            ST_ENC:    if (r_cnt == w_last_stage) w_next = ST_STORE;
            ST_STORE:  if (r_cnt == w_words - CW'(1))
                           w_next = (r_pkts == 6'd1) ? ST_DONE : ST_RD_HDR;
            ST_DONE:   if (!module_en) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
        // Dropping the enable anywhere but DONE abandons the run.
        if (!module_en && r_state != ST_DONE) w_next = ST_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_pkts  <= '0;
            r_ncode <= NC_128;
            r_v     <= '0;
            r_raddr <= '0;
            r_waddr <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state) ? '0 : r_cnt + CW'(1);
            case (r_state)
                ST_IDLE: begin
                    r_raddr <= '0;
                    r_waddr <= '0;
                end
                ST_RD_CNT: if (r_cnt == CW'(1)) begin
                    r_pkts  <= rdata[5:0];
                    r_raddr <= r_raddr + AW'(1);
                end
                ST_RD_HDR: if (r_cnt == CW'(1)) begin
                    r_ncode <= ncode_e'(rdata[1:0]);
                    r_raddr <= r_raddr + AW'(1);
                end
                ST_LOAD: begin
                    // Word k-1 lands in cycle k; cycle 0 zero-fills above N.
                    if (r_cnt == '0) r_v <= '0;
                    else             r_v[DW*int'(w_lidx) +: DW] <= rdata;
                    if (r_cnt < w_words) r_raddr <= r_raddr + AW'(1);
                end
                ST_ENC: r_v <= w_stage_v;
                ST_STORE: begin
                    r_waddr <= r_waddr + AW'(1);
                    if (r_cnt == w_words - CW'(1)) r_pkts <= r_pkts - 6'd1;
                end
                default: ;
            endcase
        end
    end

    assign proc_done = (r_state == ST_DONE);
    assign raddr     = r_raddr;
    assign wen       = (r_state == ST_STORE) && module_en;
    assign waddr     = r_waddr;
    assign wdata     = w_xout[DW*int'(w_sidx) +: DW];

endmodule

`default_nettype wire

// File: tb/tb_polar_encoder.sv
// =============================================================================
// Module : tb_polar_encoder
// Brief  : Scoreboard bench for polar_encoder; honours POLAR_ENC_BITREV_EN.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

module tb_polar_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        module_en;
    logic        proc_done;
    logic [11:0] raddr;
    logic [63:0] rdata;
    logic        wen;
    logic [11:0] waddr;
    logic [63:0] wdata;

    polar_encoder #(.DW(64), .NMAX(512), .AW(12)) dut (
        .clk       (clk),
        .rst       (rst),
        .module_en (module_en),
        .proc_done (proc_done),
        .raddr     (raddr),
        .rdata     (rdata),
        .wen       (wen),
        .waddr     (waddr),
        .wdata     (wdata)
    );

    always #5 clk = ~clk;

    logic [63:0] mem [0:4095];
    always @(posedge clk) rdata <= mem[raddr];

    typedef struct packed {
        logic [11:0] a;
        logic [63:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   runs_q[$];
    int   run_len = 0;
    int   wen_total = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    logic [511:0] pk_u [3];
    int           pk_c [3];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: every write strobe pops one expected word.
    always @(negedge clk) begin
        if (!rst && wen) begin
            exp_t e;
            wen_total++;
            run_len++;
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: waddr=%0d wdata=%h, expected no write", waddr, wdata);
            end else begin
                e = exp_q.pop_front();
                if (waddr !== e.a || wdata !== e.d) begin
                    n_fail++;
                    $display("FAIL write_word: got addr %0d data %h expected addr %0d data %h",
                             waddr, wdata, e.a, e.d);
                end
            end
        end else if (run_len != 0) begin
            runs_q.push_back(run_len);
            run_len = 0;
        end
    end

    function automatic int nbits(input int code);
        return (code == 0) ? 128 : (code == 1) ? 256 : 512;
    endfunction

    function automatic int rev(input int i, input int n);
        int r = 0;
        for (int b = 0; b < n; b++) if (((i >> b) & 1) != 0) r |= 1 << (n - 1 - b);
        return r;
    endfunction

    // Generator-matrix form: x[j] = XOR of u[i] over all i whose bits cover j.
    function automatic logic [511:0] ref_encode(input logic [511:0] u, input int nb);
        logic [511:0] x, y;
        int n;
        x = '0;
        for (int j = 0; j < nb; j++) begin
            logic acc = 1'b0;
            for (int i = 0; i < nb; i++) if ((i & j) == j) acc ^= u[i];
            x[j] = acc;
        end
        n = $clog2(nb);
        y = x;
`ifdef POLAR_ENC_BITREV_EN
        for (int i = 0; i < nb; i++) y[i] = x[rev(i, n)];
`endif
        return y;
    endfunction

    task automatic rand_u(output logic [511:0] u, input int nb);
        u = '0;
        for (int w = 0; w < 16; w++) u[w*32 +: 32] = $urandom;
        for (int i = nb; i < 512; i++) u[i] = 1'b0;
    endtask

    task automatic setup_mem(input int p);
        int a = 1;
        mem[0] = 64'(p);
        for (int k = 0; k < p; k++) begin
            mem[a] = 64'(pk_c[k]);
            a++;
            for (int w = 0; w < nbits(pk_c[k]) / 64; w++) begin
                mem[a] = pk_u[k][w*64 +: 64];
                a++;
            end
        end
    endtask

    task automatic push_exp(input int k0, input int k1, input int wa0);
        int wa = wa0;
        for (int k = k0; k <= k1; k++) begin
            logic [511:0] x = ref_encode(pk_u[k], nbits(pk_c[k]));
            for (int w = 0; w < nbits(pk_c[k]) / 64; w++) begin
                exp_q.push_back('{a: 12'(wa), d: x[w*64 +: 64]});
                wa++;
            end
        end
    endtask

    task automatic run(input string nm, input int exp_lat);
        int lat = 0;
        @(negedge clk) module_en = 1'b1;
        @(posedge clk);
        while (lat < 2000) begin
            @(posedge clk); #1;
            lat++;
            if (proc_done) break;
        end
        chk({nm, "_latency"}, 64'(lat), 64'(exp_lat));
        repeat (2) begin
            @(posedge clk); #1;
            chk({nm, "_done_hold"}, 64'(proc_done), 64'd1);
        end
        chk({nm, "_drain"}, 64'(exp_q.size()), 64'd0);
        @(negedge clk) module_en = 1'b0;
        @(posedge clk); #1;
        chk({nm, "_done_clear"}, 64'(proc_done), 64'd0);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_proc_done"}, 64'(proc_done), 64'd0);
        chk({nm, "_wen"},       64'(wen),       64'd0);
        chk({nm, "_raddr"},     64'(raddr),     64'd0);
        chk({nm, "_waddr"},     64'(waddr),     64'd0);
        chk({nm, "_wdata"},     wdata,          64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int w0;
        logic [511:0] x;
        rst = 1'b1;
        module_en = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        #1 chk_zero("reset");
        @(negedge clk) rst = 1'b0;

        // Only u[127] set, N=128: every codeword bit is 1 in either order.
        pk_c[0] = 0; pk_u[0] = '0; pk_u[0][127] = 1'b1;
        setup_mem(1);
        exp_q.push_back('{a: 12'd0, d: 64'hFFFF_FFFF_FFFF_FFFF});
        exp_q.push_back('{a: 12'd1, d: 64'hFFFF_FFFF_FFFF_FFFF});
        run("u127", 16);

        // Only u[0] set: x = e0 in both orders; waddr restarts at 0.
        pk_u[0] = '0; pk_u[0][0] = 1'b1;
        setup_mem(1);
        exp_q.push_back('{a: 12'd0, d: 64'h1});
        exp_q.push_back('{a: 12'd1, d: 64'h0});
        run("u0", 16);

        // Code 3 behaves as N=512; u[511] alone gives all ones.
        pk_c[0] = 3; pk_u[0] = '0; pk_u[0][511] = 1'b1;
        setup_mem(1);
        for (int w = 0; w < 8; w++) exp_q.push_back('{a: 12'(w), d: 64'hFFFF_FFFF_FFFF_FFFF});
        run("code3", 30);

        // Three packets of 128/256/512 bits: 14 words, contiguous per packet.
        for (int k = 0; k < 3; k++) begin
            pk_c[k] = k;
            rand_u(pk_u[k], nbits(k));
        end
        setup_mem(3);
        runs_q.delete();
        push_exp(0, 2, 0);
        run("three_pkt", 63);
        chk("three_pkt_runs", 64'(runs_q.size()), 64'd3);
        if (runs_q.size() == 3) begin
            chk("three_pkt_run0", 64'(runs_q[0]), 64'd2);
            chk("three_pkt_run1", 64'(runs_q[1]), 64'd4);
            chk("three_pkt_run2", 64'(runs_q[2]), 64'd8);
        end

        // P=0: straight to DONE, no writes.
        mem[0] = 64'd0;
        w0 = wen_total;
        run("p0", 2);
        chk("p0_no_wen", 64'(wen_total - w0), 64'd0);

        // Reset during ENC of packet 2, then a clean rerun.
        setup_mem(3);
        push_exp(0, 0, 0);
        @(negedge clk) module_en = 1'b1;
        n = 0;
        while (!wen && n < 200) begin @(negedge clk); n++; end
        chk("rst_pkt1_store", 64'(wen), 64'd1);
        n = 0;
        while (wen && n < 50) begin @(negedge clk); n++; end
        repeat (9) @(posedge clk);
        #1 rst = 1'b1; module_en = 1'b0;
        #1 chk_zero("rst_mid");
        chk("rst_mid_queue", 64'(exp_q.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1 chk_zero("rst_hold");
        @(negedge clk) rst = 1'b0;
        push_exp(0, 2, 0);
        run("rerun", 63);

        // Abort in the middle of STORE of a 512-bit packet.
        pk_c[0] = 2;
        rand_u(pk_u[0], 512);
        setup_mem(1);
        x = ref_encode(pk_u[0], 512);
        for (int w = 0; w < 3; w++) exp_q.push_back('{a: 12'(w), d: x[w*64 +: 64]});
        @(negedge clk) module_en = 1'b1;
        n = 0;
        while (!wen && n < 200) begin @(negedge clk); n++; end
        chk("abort_store_seen", 64'(wen), 64'd1);
        repeat (2) @(negedge clk);
        #1 module_en = 1'b0;
        @(posedge clk); #1;
        chk("abort_wen", 64'(wen), 64'd0);
        chk("abort_done", 64'(proc_done), 64'd0);
        @(posedge clk); #1;
        chk("abort_idle_raddr", 64'(raddr), 64'd0);
        chk("abort_idle_waddr", 64'(waddr), 64'd0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("abort_done_low", 64'(proc_done), 64'd0);
        end
        chk("abort_queue", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
